led_scan_controller: RTL and testbench
======================================

Name: led_scan_controller

Overview:
Time-multiplexes the single 4-bit-char seven-segment decoder across a 4-digit common-anode display. Holds a shadow buffer of four 4-bit character codes written by the host and commits them atomically to the active buffer at frame boundaries. Sequences the digit slots with a prescaler and inserts a blanking guard at the start of each slot to prevent ghosting. char_out feeds the decoder's char input; an drives the digit anodes.

Parameters:
PRESCALE, 16, clock cycles per digit slot (must be >= 2)
BLANK, 2, cycles at the start of each slot with all anodes off (0 <= BLANK < PRESCALE; 0 disables blanking)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write shadow[wr_addr] <= wr_data on this edge
wr_addr  input  2  shadow digit index (0 = rightmost)
wr_data  input  4  character code (0-9 digits, 1010 dash, 1111 F, others blank)
commit  input  1  request active <= shadow at the next frame boundary
commit_pending  output  1  commit requested, not yet applied
char_out  output  4  active[digit_sel], to decoder char input
an  output  4  anode enables, active-low, one-hot-low or all ones
digit_sel  output  2  current slot index
frame_tick  output  1  high in the last cycle of a frame

Behaviour:
- State: cnt (clog2(PRESCALE) bits), digit_sel (2 bits), shadow[0..3], active[0..3], commit_pending.
- Reset (synchronous): cnt=0, digit_sel=0, commit_pending=0, every shadow and active entry = 4'b1010 (display shows "----"). After the reset edge: char_out=1010; an=1111 if BLANK>=1, else 1110; frame_tick=0.
- Reset asserted mid-frame or mid-commit: all state returns to reset values on that edge. Pending commits and shadow writes from that cycle are discarded.
- Prescaler: cnt increments each cycle. At cnt==PRESCALE-1, cnt wraps to 0 and digit_sel increments mod 4 (3 wraps to 0).
- an, char_out and frame_tick are combinational decodes of registered state, with zero added latency.
  - an: if cnt < BLANK, an=1111; otherwise an[digit_sel]=0 and all other bits are 1.
  - char_out = active[digit_sel]. It changes in the same cycle digit_sel changes, and that cycle is always inside the blank window when BLANK>=1.
  - frame_tick = (digit_sel==3) and (cnt==PRESCALE-1).
- Frame = 4*PRESCALE cycles. The frame boundary is the clock edge on which frame_tick=1.
- Writes: when wr_en=1, shadow[wr_addr] <= wr_data on the edge. Writes never alter active directly.
- Commit:
  - commit=1 on a non-boundary edge sets commit_pending=1.
  - commit=1 while already pending has no further effect.
  - At the boundary edge, if commit_pending=1 or commit=1, then active <= shadow and commit_pending <= 0. Otherwise active holds.
  - A write in the same cycle as the boundary commit is included: that entry takes wr_data.
  - A commit on the boundary cycle never raises commit_pending.
- The shadow may be written freely while a commit is pending. The snapshot taken at the boundary edge is what gets displayed.
- No other outputs depend on wr_* or commit combinationally.

Test Plan:
1. Defaults, release reset at t0 -> an=1111 at cnt 0-1, an=1110 at cnt 2-15, char_out=1010. digit_sel=1 from t0+16 with an=1101 from t0+18. frame_tick high only at t0+63, period 64.
2. Write 0001,0010,0011,0100 to addr 0..3, no commit -> char_out stays 1010 in every slot for 2 full frames, commit_pending=0.
3. Pulse commit at digit_sel=1, cnt=5 -> commit_pending=1 from the next cycle until the boundary edge, then 0. The following frame shows char_out 0001/0010/0011/0100 in slots 0/1/2/3.
4. In the frame_tick cycle, assert commit and write addr2=1111 together -> commit_pending never rises. In the next frame, slot 2 shows 1111 and slots 0, 1, 3 show the previously written shadow values.
5. Commit pending, then reset asserted at digit_sel=2, cnt=7 -> next cycle: cnt=0, digit_sel=0, commit_pending=0, char_out=1010, an=1111. The old pending commit is never applied.
6. BLANK=0, PRESCALE=4 -> an is never 1111 after reset and cycles 1110,1101,1011,0111 every 4 cycles. frame_tick has period 16.

Source files
------------

// File: rtl/led_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with a host-written shadow buffer.
// The shadow buffer is copied atomically to the displayed buffer on frame boundaries.
module led_scan_controller #(
  parameter int PRESCALE = 16,
  parameter int BLANK    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  output logic [3:0] char_out,
  output logic [3:0] an,
  output logic [1:0] digit_sel,
  output logic       frame_tick
);

  localparam int              CW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [3:0]      DASH     = 4'b1010;

  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      digit_sel_reg, digit_sel_next;
  logic            commit_pending_reg, commit_pending_next;
  logic [3:0][3:0] shadow_reg, shadow_next;
  logic [3:0][3:0] active_reg, active_next;

  logic slot_end;
  logic boundary;
  logic apply;
  logic blank;

  assign slot_end = (cnt_reg == CNT_LAST);
  assign boundary = slot_end && (digit_sel_reg == 2'd3);
  // A commit arriving on the boundary itself is applied immediately, never queued.
  assign apply    = boundary && (commit_pending_reg || commit);

  always_comb begin
    cnt_next            = cnt_reg + CW'(1);
    digit_sel_next      = digit_sel_reg;
    commit_pending_next = commit_pending_reg;
    if (slot_end) begin
      cnt_next       = '0;
      digit_sel_next = digit_sel_reg + 2'd1;
    end
    if (boundary) begin
      commit_pending_next = 1'b0;
    end else if (commit) begin
      commit_pending_next = 1'b1;
    end
  end

  // Snapshot uses shadow_next so a write landing on the boundary edge is included.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
      assign shadow_next[gi] = (wr_en && (wr_addr == 2'(gi))) ? wr_data : shadow_reg[gi];
      assign active_next[gi] = apply ? shadow_next[gi] : active_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg            <= '0;
      digit_sel_reg      <= 2'd0;
      commit_pending_reg <= 1'b0;
      shadow_reg         <= {4{DASH}};
      active_reg         <= {4{DASH}};
    end else begin
      cnt_reg            <= cnt_next;
      digit_sel_reg      <= digit_sel_next;
      commit_pending_reg <= commit_pending_next;
      shadow_reg         <= shadow_next;
      active_reg         <= active_next;
    end
  end

  generate
    if (BLANK == 0) begin : g_noblank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (cnt_reg < CW'(BLANK));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign an[gi] = blank || (digit_sel_reg != 2'(gi));
    end
  endgenerate

  assign char_out       = active_reg[digit_sel_reg];
  assign digit_sel      = digit_sel_reg;
  assign commit_pending = commit_pending_reg;
  assign frame_tick     = boundary;

endmodule

// File: tb/tb_led_scan_controller.sv
// Bench for led_scan_controller: timing table, directed commit/reset sequences,
// randomized traffic against a cycle-index reference model, and a no-blank instance.
module tb_led_scan_controller;

  localparam int P  = 16;
  localparam int B  = 2;
  localparam int FR = 4 * P;

  logic       clk = 1'b0;
  logic       reset, wr_en, commit;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit_pending, frame_tick;
  logic [3:0] char_out, an;
  logic [1:0] digit_sel;

  logic       reset_b;
  logic       pend_b, tick_b;
  logic [3:0] char_b, an_b;
  logic [1:0] sel_b;

  always #5 clk = ~clk;

  led_scan_controller #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending), .char_out(char_out), .an(an),
    .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  led_scan_controller #(.PRESCALE(4), .BLANK(0)) dut_b (
    .clk(clk), .reset(reset_b), .wr_en(1'b0), .wr_addr(2'd0), .wr_data(4'd0),
    .commit(1'b0), .commit_pending(pend_b), .char_out(char_b), .an(an_b),
    .digit_sel(sel_b), .frame_tick(tick_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position derived from the cycle index since reset.
  int         t;
  logic [3:0] m_sh [4];
  logic [3:0] m_act[4];
  bit         m_pend;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [3:0] ch;
    logic [1:0] sel;
    logic       tick;
  } tvec_t;

  tvec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_pend = 0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = 4'b1010;
      m_act[i] = 4'b1010;
    end
  endtask

  task automatic check_model(input string tag);
    int         c, d;
    logic [3:0] e_an, one;
    bit         bad;
    c   = t % P;
    d   = (t / P) % 4;
    one = 4'b0001;
    e_an = (c < B) ? 4'hF : ~(one << d);
    bad = (an !== e_an) || (char_out !== m_act[d]) || (digit_sel !== 2'(d)) ||
          (frame_tick !== ((t % FR) == FR - 1)) || (commit_pending !== m_pend);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s t=%0d: got an=%b ch=%h sel=%0d tick=%b pend=%b expected an=%b ch=%h sel=%0d tick=%b pend=%b",
               tag, t, an, char_out, digit_sel, frame_tick, commit_pending,
               e_an, m_act[d], d, (t % FR) == FR - 1, m_pend);
    end
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, clock, advance the model.
  task automatic step(input bit r, input bit we, input logic [1:0] wa,
                      input logic [3:0] wd, input bit cm);
    bit         bnd;
    logic [3:0] nsh[4];
    reset = r; wr_en = we; wr_addr = wa; wr_data = wd; commit = cm;
    check_model("model");
    tick();
    if (r) begin
      model_reset();
    end else begin
      bnd = ((t % FR) == FR - 1);
      nsh = m_sh;
      if (we) nsh[wa] = wd;
      if (bnd) begin
        if (m_pend || cm) m_act = nsh;
        m_pend = 0;
      end else if (cm) begin
        m_pend = 1;
      end
      m_sh = nsh;
      t++;
    end
    reset = 0; wr_en = 0; commit = 0;
  endtask

  task automatic idle();
    step(0, 0, 2'd0, 4'd0, 0);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FR && (t % FR) != phase; i++) idle();
  endtask

  initial begin
    reset = 1; wr_en = 0; commit = 0; wr_addr = 0; wr_data = 0; reset_b = 1;
    tick(); tick();
    model_reset();

    // 1: slot timing table relative to reset release
    tbl.push_back('{0,   4'hF, 4'hA, 2'd0, 1'b0});
    tbl.push_back('{1,   4'hF, 4'hA, 2'd0, 1'b0});
    tbl.push_back('{2,   4'hE, 4'hA, 2'd0, 1'b0});
    tbl.push_back('{15,  4'hE, 4'hA, 2'd0, 1'b0});
    tbl.push_back('{16,  4'hF, 4'hA, 2'd1, 1'b0});
    tbl.push_back('{18,  4'hD, 4'hA, 2'd1, 1'b0});
    tbl.push_back('{34,  4'hB, 4'hA, 2'd2, 1'b0});
    tbl.push_back('{50,  4'h7, 4'hA, 2'd3, 1'b0});
    tbl.push_back('{62,  4'h7, 4'hA, 2'd3, 1'b0});
    tbl.push_back('{63,  4'h7, 4'hA, 2'd3, 1'b1});
    tbl.push_back('{64,  4'hF, 4'hA, 2'd0, 1'b0});
    tbl.push_back('{126, 4'h7, 4'hA, 2'd3, 1'b0});
    tbl.push_back('{127, 4'h7, 4'hA, 2'd3, 1'b1});
    foreach (tbl[i]) begin
      while (t < tbl[i].k) idle();
      chk($sformatf("t1_an@%0d", tbl[i].k),   {4'h0, an},        {4'h0, tbl[i].an});
      chk($sformatf("t1_char@%0d", tbl[i].k), {4'h0, char_out},  {4'h0, tbl[i].ch});
      chk($sformatf("t1_sel@%0d", tbl[i].k),  {6'h0, digit_sel}, {6'h0, tbl[i].sel});
      chk($sformatf("t1_tick@%0d", tbl[i].k), {7'h0, frame_tick}, {7'h0, tbl[i].tick});
    end

    // 2: writes without commit never reach the display
    run_to(0);
    for (int a = 0; a < 4; a++) step(0, 1, 2'(a), 4'(a + 1), 0);
    for (int i = 0; i < 2 * FR; i++) begin
      if ((t % P) == 8) chk("t2_char", {4'h0, char_out}, 8'h0A);
      idle();
    end
    chk("t2_pend", {7'h0, commit_pending}, 8'h00);

    // 3: commit mid-frame is deferred to the boundary
    run_to(16 + 5);
    step(0, 0, 2'd0, 4'd0, 1);
    chk("t3_pend_set", {7'h0, commit_pending}, 8'h01);
    run_to(FR - 1);
    chk("t3_pend_hold", {7'h0, commit_pending}, 8'h01);
    idle();
    chk("t3_pend_clr", {7'h0, commit_pending}, 8'h00);
    for (int s = 0; s < 4; s++) begin
      run_to(s * P + 4);
      chk($sformatf("t3_slot%0d", s), {4'h0, char_out}, {4'h0, 4'(s + 1)});
    end

    // 4: commit and write together on the boundary cycle
    run_to(FR - 1);
    step(0, 1, 2'd2, 4'hF, 1);
    chk("t4_pend", {7'h0, commit_pending}, 8'h00);
    run_to(4);       chk("t4_slot0", {4'h0, char_out}, 8'h01);
    run_to(P + 4);   chk("t4_slot1", {4'h0, char_out}, 8'h02);
    run_to(2*P + 4); chk("t4_slot2", {4'h0, char_out}, 8'h0F);
    run_to(3*P + 4); chk("t4_slot3", {4'h0, char_out}, 8'h04);

    // 5: reset while a commit is pending discards it
    step(0, 1, 2'd0, 4'h9, 0);
    run_to(5);
    step(0, 0, 2'd0, 4'd0, 1);
    run_to(2*P + 7);
    step(1, 0, 2'd0, 4'd0, 0);
    chk("t5_sel",  {6'h0, digit_sel},      8'h00);
    chk("t5_pend", {7'h0, commit_pending}, 8'h00);
    chk("t5_char", {4'h0, char_out},       8'h0A);
    chk("t5_an",   {4'h0, an},             8'h0F);
    run_to(FR - 1);
    idle();
    run_to(4);
    chk("t5_noapply", {4'h0, char_out}, 8'h0A);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit cm;
      cm = ($urandom_range(0, 39) == 0) || (((t % FR) == FR - 1) && $urandom_range(0, 2) == 0);
      step($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), cm);
    end
    check_model("final");

    // 6: PRESCALE=4, BLANK=0 instance
    reset_b = 0;
    for (int k = 0; k < 64; k++) begin
      logic [3:0] e, one;
      one = 4'b0001;
      e = ~(one << ((k / 4) % 4));
      chk($sformatf("t6_an@%0d", k),   {4'h0, an_b},    {4'h0, e});
      chk($sformatf("t6_tick@%0d", k), {7'h0, tick_b},  {7'h0, (k % 16) == 15});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // The second instance is held in reset during the main sequence, then released.
  initial begin
    @(negedge reset_b);
  end

endmodule
